// File: rtl/co_alu_pkg.sv
// Shared ALU definitions: ALUCtrl code constants (also used by the ALU
// controller), the execute-stage state encoding and a small decode helper.
package co_alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_LUI  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_BNE  = 4'b1010;
   localparam logic [3:0] ALU_SRAV = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // True for the codes that go through the arithmetic right shifter
   function automatic logic is_shift_op(input logic [3:0] code);
      return (code == ALU_SRA) || (code == ALU_SRAV);
   endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Arithmetic right shifter for sra/srav.
// Default build: working register plus down-counter, one bit per step.
// With ALU_SEQ_BARREL_EN defined the shift is a single combinational
// barrel stage on data_in/amt_in and no state is kept.
module alu_seq_shifter #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load,
   input  logic               step,
   input  logic [DATA_W-1:0]  data_in,
   input  logic [SHAMT_W-1:0] amt_in,
   output logic [DATA_W-1:0]  shift_out,
   output logic               last
);

`ifdef ALU_SEQ_BARREL_EN

   // Whole shift in one pass; the step interface is never exercised
   assign shift_out = $signed(data_in) >>> amt_in;
   assign last      = 1'b1;

`else

   logic [DATA_W-1:0]  work_q;
   logic [SHAMT_W-1:0] count_q;

   // Load operand and amount on start, then shift by one and count down per step
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         work_q  <= '0;
         count_q <= '0;
      end else if (load) begin
         work_q  <= data_in;
         count_q <= amt_in;
      end else if (step) begin
         work_q  <= shift_out;
         count_q <= count_q - SHAMT_W'(1);
      end
   end

   // shift_out is the value after the step in progress, so the final step's
   // result can be captured on the same edge that leaves SHIFT
   assign shift_out = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
   assign last      = (count_q == SHAMT_W'(1));

`endif

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with start/done handshake. Single-cycle ops finish in
// one cycle; sra/srav shift iteratively unless ALU_SEQ_BARREL_EN is defined,
// in which case every op finishes in one cycle.
module alu_seq_exec
   import co_alu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [3:0]         ctrl_i,
   input  logic [DATA_W-1:0]  src1_i,
   input  logic [DATA_W-1:0]  src2_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [DATA_W-1:0]  result_o,
   output logic               zero_o,
   output logic               overflow_o
);

   state_t              state_q, state_d;
   logic [SHAMT_W-1:0]  shift_amt;
   logic [DATA_W-1:0]   shift_out;
   logic                shift_last;
   logic                shift_load, shift_step;
   logic [DATA_W-1:0]   sum, diff;
   logic [DATA_W-1:0]   op_res;
   logic                op_zero, op_ovf;
   logic                cap;
   logic [DATA_W-1:0]   cap_res;
   logic                cap_zero, cap_ovf;

   // sra takes the instruction shamt field, srav the low bits of rs
   assign shift_amt = (ctrl_i == ALU_SRAV) ? src1_i[SHAMT_W-1:0] : shamt_i;
   assign sum       = src1_i + src2_i;
   assign diff      = src1_i - src2_i;

   alu_seq_shifter #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (shift_load),
      .step      (shift_step),
      .data_in   (src2_i),
      .amt_in    (shift_amt),
      .shift_out (shift_out),
      .last      (shift_last)
   );

   // Single-cycle result and flags computed straight from the inputs
   always_comb begin
      op_res = '0;
      op_ovf = 1'b0;
      case (ctrl_i)
         ALU_AND: op_res = src1_i & src2_i;
         ALU_OR:  op_res = src1_i | src2_i;
         ALU_ADD: begin
            op_res = sum;
            op_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                     (sum[DATA_W-1] != src1_i[DATA_W-1]);
         end
         ALU_SUB: begin
            op_res = diff;
            op_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                     (diff[DATA_W-1] != src1_i[DATA_W-1]);
         end
         ALU_SLT: op_res = DATA_W'($signed(src1_i) < $signed(src2_i));
         ALU_LUI: op_res = DATA_W'(src2_i[15:0]) << 16;
`ifdef ALU_SEQ_BARREL_EN
         ALU_SRA, ALU_SRAV: op_res = shift_out;
`else
         ALU_SRA, ALU_SRAV: op_res = src2_i;
`endif
         ALU_BNE: op_res = diff;
         default: op_res = '0;
      endcase
      op_zero = (ctrl_i == ALU_BNE) ? (src1_i != src2_i) : (op_res == '0);
   end

   // Next-state logic plus shifter control and result-capture selection
   always_comb begin
      state_d    = state_q;
      shift_load = 1'b0;
      shift_step = 1'b0;
      cap        = 1'b0;
      cap_res    = op_res;
      cap_zero   = op_zero;
      cap_ovf    = op_ovf;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
`ifdef ALU_SEQ_BARREL_EN
               cap     = 1'b1;
               state_d = ST_DONE;
`else
               if (is_shift_op(ctrl_i) && (shift_amt != '0)) begin
                  shift_load = 1'b1;
                  state_d    = ST_SHIFT;
               end else begin
                  cap     = 1'b1;
                  state_d = ST_DONE;
               end
`endif
            end
         end
         ST_SHIFT: begin
            shift_step = 1'b1;
            if (shift_last) begin
               cap      = 1'b1;
               cap_res  = shift_out;
               cap_zero = (shift_out == '0);
               cap_ovf  = 1'b0;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset aborts any shift in flight
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output registers update only on the edge that enters DONE and hold otherwise
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         result_o   <= '0;
         zero_o     <= 1'b0;
         overflow_o <= 1'b0;
      end else if (cap) begin
         result_o   <= cap_res;
         zero_o     <= cap_zero;
         overflow_o <= cap_ovf;
      end
   end

   assign busy_o = (state_q == ST_SHIFT);
   assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed testbench for alu_seq_exec; expected latencies follow
// ALU_SEQ_BARREL_EN when it is defined for the build.
module tb_alu_seq_exec;
   import co_alu_pkg::*;

   logic        clk_i   = 1'b0;
   logic        rst_i   = 1'b0;
   logic        start_i = 1'b0;
   logic [3:0]  ctrl_i  = '0;
   logic [31:0] src1_i  = '0;
   logic [31:0] src2_i  = '0;
   logic [4:0]  shamt_i = '0;
   logic        busy_o, done_o, zero_o, overflow_o;
   logic [31:0] result_o;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   alu_seq_exec #(
      .DATA_W  (32),
      .SHAMT_W (5)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .ctrl_i     (ctrl_i),
      .src1_i     (src1_i),
      .src2_i     (src2_i),
      .shamt_i    (shamt_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .zero_o     (zero_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int shift_lat(input int amount);
`ifdef ALU_SEQ_BARREL_EN
      return 1;
`else
      return (amount == 0) ? 1 : amount + 1;
`endif
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Present a request for exactly one edge; returns #1 after that edge
   task automatic apply_stimulus(input logic [3:0] ctrl, input logic [31:0] s1,
                                 input logic [31:0] s2, input logic [4:0] sh);
      @(negedge clk_i);
      ctrl_i  = ctrl;
      src1_i  = s1;
      src2_i  = s2;
      shamt_i = sh;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
   endtask

   // Bounded wait for done_o; lat counts cycles since the start edge
   task automatic wait_done(inout int lat);
      while (done_o !== 1'b1 && lat < 100) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] ctrl,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] sh, input logic [31:0] exp_res,
                         input logic exp_zero, input logic exp_ovf, input int exp_lat);
      int lat;
      apply_stimulus(ctrl, s1, s2, sh);
      lat = 1;
      wait_done(lat);
      check_output({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_output({tag, "_res"}, result_o, exp_res);
      check_output({tag, "_zero"}, 32'(zero_o), 32'(exp_zero));
      check_output({tag, "_ovf"}, 32'(overflow_o), 32'(exp_ovf));
      @(posedge clk_i);
      #1;
      check_output({tag, "_pulse"}, 32'(done_o), 32'd0);
   endtask

   initial begin
      int lat;
      int pulses;

      // Reset state
      #12;
      check_output("rst_busy", 32'(busy_o), 32'd0);
      check_output("rst_done", 32'(done_o), 32'd0);
      check_output("rst_res", result_o, 32'd0);
      check_output("rst_zero", 32'(zero_o), 32'd0);
      check_output("rst_ovf", 32'(overflow_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      // Single-cycle ops
      run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1);
      run_op("sub_zero", ALU_SUB, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1, 1'b0, 1);
      run_op("sub_ovf", ALU_SUB, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
      run_op("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0, 1);
      run_op("or", ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1);
      run_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1);
      run_op("slt_pos", ALU_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, 1'b0, 1);
      run_op("lui", ALU_LUI, 32'h0, 32'h0000_ABCD, 5'd0, 32'hABCD_0000, 1'b0, 1'b0, 1);

      // sra by 4 with a second request injected while busy
      apply_stimulus(ALU_SRA, 32'h0, 32'h8000_0000, 5'd4);
      lat = 1;
`ifndef ALU_SEQ_BARREL_EN
      check_output("sra_busy", 32'(busy_o), 32'd1);
      ctrl_i  = ALU_ADD;
      src1_i  = 32'h0000_0001;
      src2_i  = 32'h0000_0001;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      lat = 2;
`endif
      wait_done(lat);
      check_output("sra_lat", 32'(lat), 32'(shift_lat(4)));
      check_output("sra_res", result_o, 32'hF800_0000);
      check_output("sra_zero", 32'(zero_o), 32'd0);
      check_output("sra_busy_done", 32'(busy_o), 32'd0);
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      check_output("sra_no_extra", 32'(done_o), 32'd0);
      check_output("sra_hold", result_o, 32'hF800_0000);

      run_op("sra_1", ALU_SRA, 32'h0, 32'h4000_0000, 5'd1, 32'h2000_0000, 1'b0, 1'b0, shift_lat(1));
      run_op("srav_0", ALU_SRAV, 32'h20, 32'h1234, 5'd7, 32'h1234, 1'b0, 1'b0, 1);
      run_op("srav_3", ALU_SRAV, 32'h3, 32'hFFFF_FFF0, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, shift_lat(3));
      run_op("bne_eq", ALU_BNE, 32'd4, 32'd4, 5'd0, 32'h0, 1'b0, 1'b0, 1);
      run_op("bne_ne", ALU_BNE, 32'd3, 32'd4, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
      run_op("undef", 4'b1111, 32'h1234, 32'h5678, 5'd3, 32'h0, 1'b1, 1'b0, 1);

      // start held through the DONE cycle must not be taken there
      apply_stimulus(ALU_ADD, 32'd1, 32'd2, 5'd0);
      start_i = 1'b1;
      src1_i  = 32'd10;
      check_output("dstart_done", 32'(done_o), 32'd1);
      check_output("dstart_res", result_o, 32'd3);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      check_output("dstart_ignored", 32'(done_o), 32'd0);
      check_output("dstart_hold", result_o, 32'd3);
      @(posedge clk_i);
      #1;
      check_output("dstart_idle", 32'(done_o), 32'd0);

      // Reset mid-run after a non-zero result
      run_op("pre_rst", ALU_BNE, 32'd3, 32'd4, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
      apply_stimulus(ALU_SRA, 32'h0, 32'h8000_0000, 5'd8);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      check_output("mid_rst_busy", 32'(busy_o), 32'd0);
      check_output("mid_rst_done", 32'(done_o), 32'd0);
      check_output("mid_rst_res", result_o, 32'd0);
      check_output("mid_rst_zero", 32'(zero_o), 32'd0);
      check_output("mid_rst_ovf", 32'(overflow_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk_i);
         #1;
         if (done_o === 1'b1) pulses++;
      end
      check_output("mid_rst_no_done", 32'(pulses), 32'd0);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Execute-stage ALU that sits directly downstream of the ALU controller and consumes its 4-bit ALUCtrl code plus the register/immediate operands.
- Single-cycle ops complete in 1 cycle.
- Arithmetic right shifts (sra/srav) run iteratively, 1 bit per cycle.
- Start/done handshake towards the datapath sequencer.
- Result and zero flag feed writeback and branch logic.

Parameters:
DATA_W, 32, operand/result width
SHAMT_W, 5, shift-amount width (log2 DATA_W)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  request; sampled only in IDLE
ctrl_i  in  4  ALUCtrl code from ALU controller
src1_i  in  DATA_W  operand 1 (rs value)
src2_i  in  DATA_W  operand 2 (rt value or extended immediate)
shamt_i  in  SHAMT_W  instruction shamt field
busy_o  out  1  high while operation in flight
done_o  out  1  one-cycle pulse, result valid
result_o  out  DATA_W  result, held until next done
zero_o  out  1  branch/zero flag, held with result
overflow_o  out  1  signed overflow for add/sub, else 0

Behaviour:
- Reset (async, rst_i=0): state IDLE; busy_o=0, done_o=0, result_o=0, zero_o=0, overflow_o=0, shift counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE + start_i=1:
  - latch ctrl_i, src1_i, src2_i, shift amount.
  - Non-shift codes -> DONE.
  - Shift codes -> SHIFT, or straight to DONE if amount=0.
  - busy_o=1 from the next cycle.
- IDLE + start_i=0: stay in IDLE.
- SHIFT:
  - each cycle, working reg = arithmetic right shift by 1 (MSB replicated); counter decrements.
  - When counter reaches 1, the final shift is taken and the state moves to DONE.
- DONE:
  - done_o=1 for exactly one cycle; result_o/zero_o/overflow_o updated on the same edge.
  - Next state IDLE.
  - busy_o is low in DONE, so a start_i in the DONE cycle is ignored; start is accepted in IDLE only.
- start_i while busy_o=1 is ignored; latched operands are unaffected.
- Latency, start-cycle edge to done_o high: 1 cycle for single-cycle ops; amount+1 cycles for shifts (amount 0 -> 1).
- Code map (32-bit wrap arithmetic):
  - 0000 and; 0001 or; 0010 add; 0110 sub.
  - 0111 signed slt (result 1/0).
  - 1000 lui: src2[15:0]<<16.
  - 1001 sra: src2 >>> shamt_i.
  - 1010 bne: result src1-src2.
  - 1011 srav: src2 >>> src1[4:0].
- zero_o:
  - (result==0) for all codes except bne.
  - bne: zero_o=(src1!=src2), so branch logic uses zero_o uniformly.
- overflow_o: add/sub signed overflow only; result still wraps, no trap.
- Undefined codes: result 0, zero_o=1, overflow_o=0, latency 1.
- Reset mid-shift: aborts immediately; no done_o pulse; all outputs return to reset values.
- Outputs hold their values between done pulses.

Optional Feature:
ALU_SEQ_BARREL_EN
- Defined: sra/srav use a combinational barrel shifter; SHIFT state is never entered; all ops have latency 1.
- Undefined: iterative 1-bit/cycle shifter as above.
- Ports and all results are identical in both builds; only latency differs.

Decomposition:
- Shared package co_alu_pkg:
  - ALUCtrl code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_LUI, ALU_SRA, ALU_BNE, ALU_SRAV), also used by the ALU controller.
  - state encoding for IDLE/SHIFT/DONE.
- One sub-module: alu_seq_shifter.
  - holds the working register and counter; iterative or barrel depending on ALU_SEQ_BARREL_EN.
  - load/step interface and last-step flag.
- Top: FSM, combinational op unit, flags, output registers.

Test Plan:
- Reset: rst_i low mid-run -> all outputs 0, busy_o=0, no done_o.
- add: src1=0x7FFFFFFF, src2=1, ctrl=0010 -> done after 1 cycle, result 0x80000000, overflow_o=1, zero_o=0.
- sub: src1=5, src2=5, ctrl=0110 -> result 0, zero_o=1.
- slt: src1=0xFFFFFFFF, src2=1, ctrl=0111 -> result 1.
- lui: src2=0x0000ABCD, ctrl=1000 -> result 0xABCD0000.
- sra: src2=0x80000000, shamt_i=4, ctrl=1001 -> busy 4 cycles, done at cycle 5, result 0xF8000000.
  - second start_i mid-shift -> ignored.
  - barrel build -> same result, done at cycle 1.
- srav: src1=0x20 (amount 0), src2=0x1234 -> result 0x1234, latency 1.
- bne: src1=3, src2=4, ctrl=1010 -> zero_o=1, result 0xFFFFFFFF.
- undefined code 1111 -> result 0, zero_o=1.
